// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler: FSM state encoding,
// default counter width and terminal-value helpers.
package counter_sched_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  // Terminal value when counting up: all ones at width w.
  function automatic logic [31:0] term_up(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] term_down();
    return 32'd0;
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester-side handshake bundle: per-requester request, start value and
// direction in, one-hot grant and done pulse back.
interface counter_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_val;
  logic [N_REQ-1:0]       req_dir;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;

  modport master (
    output req,
    output req_val,
    output req_dir,
    input  grant,
    input  done
  );

  modport slave (
    input  req,
    input  req_val,
    input  req_dir,
    output grant,
    output done
  );

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping. The pointer itself lives in the parent.
module counter_sched_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned j;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr_i) + i) % N_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up/down counter among N_REQ requesters.
// Optional Hold input enabled by defining COUNTER_SCHED_HOLD_EN.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_sched_if.slave   rq,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_in,
  output logic             cnt_load,
  output logic             cnt_e,
  output logic             cnt_d,
  input  logic [CNT_W-1:0] cnt_q
`ifdef COUNTER_SCHED_HOLD_EN
  ,
  input  logic             hold
`endif
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] TERM_UP   = CNT_W'(term_up(CNT_W));
  localparam logic [CNT_W-1:0] TERM_DOWN = CNT_W'(term_down());

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] val_q, val_d;
  logic             dir_q, dir_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [IDX_W-1:0] ptr_next;
  logic [N_REQ-1:0] grant_vec;
  logic             req_own;
  logic             at_term;
  logic             hold_w;

`ifdef COUNTER_SCHED_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  counter_sched_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (rq.req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign req_own  = rq.req[idx_q];
  assign at_term  = (cnt_q == (dir_q ? TERM_DOWN : TERM_UP));
  assign ptr_next = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= '0;
      val_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    val_d   = val_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          idx_d   = arb_idx;
          val_d   = rq.req_val[32'(arb_idx) * CNT_W +: CNT_W];
          dir_d   = |(arb_grant & rq.req_dir);
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!req_own) begin
          ptr_d   = ptr_next;
          state_d = StIdle;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Abort wins over terminal; terminal wins over hold.
        if (!req_own) begin
          ptr_d   = ptr_next;
          state_d = StIdle;
        end else if (at_term) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = ptr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_vec = '0;
    if (state_q != StIdle) grant_vec[idx_q] = 1'b1;
  end

  assign rq.grant = grant_vec;
  assign rq.done  = (state_q == StDone) ? grant_vec : '0;
  assign busy     = (state_q != StIdle);
  assign cnt_load = (state_q == StLoad);
  assign cnt_in   = (state_q == StLoad) ? val_q : '0;
  assign cnt_d    = busy ? dir_q : 1'b0;

  always_comb begin
    cnt_e = 1'b0;
    unique case (state_q)
      StLoad:  cnt_e = req_own;
      StRun:   cnt_e = req_own && !at_term && !hold_w;
      default: cnt_e = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural 8-bit up/down counter
// closing the loop; expected values are hand-computed per scenario.
module tb_counter_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] cnt_in;
  logic             cnt_load;
  logic             cnt_e;
  logic             cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hold;

  int n_checks;
  int n_fail;

  logic [N_REQ-1:0] rr_exp [4];

  counter_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) rq_if ();

  counter_sched #(
    .N_REQ (N_REQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rq       (rq_if),
    .busy     (busy),
    .cnt_in   (cnt_in),
    .cnt_load (cnt_load),
    .cnt_e    (cnt_e),
    .cnt_d    (cnt_d),
    .cnt_q    (cnt_q)
`ifdef COUNTER_SCHED_HOLD_EN
    ,
    .hold     (hold)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter instance model: no reset, load has priority over enable.
  always @(posedge clk) begin
    if (cnt_load) cnt_q <= cnt_in;
    else if (cnt_e) cnt_q <= cnt_d ? cnt_q - 8'd1 : cnt_q + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_load(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!cnt_load && cyc < 20);
    check("load_seen", 32'(cnt_load), 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (rq_if.done == '0 && cyc < 20);
    check("done_seen", 32'(|rq_if.done), 32'd1);
  endtask

  initial begin
    int c;
    n_checks = 0;
    n_fail   = 0;
    hold     = 1'b0;
    rq_if.req     = '0;
    rq_if.req_val = '0;
    rq_if.req_dir = '0;
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;

    // Reset state
    do_reset();
    check("rst_grant", 32'(rq_if.grant), 32'd0);
    check("rst_done",  32'(rq_if.done), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_load",  32'(cnt_load), 32'd0);
    check("rst_e",     32'(cnt_e), 32'd0);
    check("rst_d",     32'(cnt_d), 32'd0);
    check("rst_in",    32'(cnt_in), 32'd0);

    // Single request: requester 0 counts down from 3
    rq_if.req_val[0 +: 8] = 8'd3;
    rq_if.req_dir[0]      = 1'b1;
    rq_if.req             = 4'b0001;
    step();
    check("s_grant", 32'(rq_if.grant), 32'h1);
    check("s_load",  32'(cnt_load), 32'd1);
    check("s_e0",    32'(cnt_e), 32'd1);
    check("s_in",    32'(cnt_in), 32'd3);
    check("s_d",     32'(cnt_d), 32'd1);
    check("s_busy",  32'(busy), 32'd1);
    for (int v = 3; v >= 1; v--) begin
      step();
      check("s_q",   32'(cnt_q), 32'(v));
      check("s_e",   32'(cnt_e), 32'd1);
      check("s_nod", 32'(rq_if.done), 32'd0);
    end
    step();
    check("s_q0",   32'(cnt_q), 32'd0);
    check("s_eterm", 32'(cnt_e), 32'd0);
    step();
    check("s_done",  32'(rq_if.done), 32'h1);
    check("s_gdone", 32'(rq_if.grant), 32'h1);
    check("s_edone", 32'(cnt_e), 32'd0);
    rq_if.req = '0;
    step();
    check("s_idle_g", 32'(rq_if.grant), 32'd0);
    check("s_idle_d", 32'(rq_if.done), 32'd0);
    check("s_idle_b", 32'(busy), 32'd0);

    // Round-robin from pointer 0 with 1011 held, each run 1 down
    do_reset();
    for (int i = 0; i < 4; i++) rq_if.req_val[i*8 +: 8] = 8'd1;
    rq_if.req_dir = 4'b1111;
    rq_if.req     = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_load(c);
      if (k > 0) check("rr_gap", 32'(c), 32'd2);
      check("rr_grant", 32'(rq_if.grant), 32'(rr_exp[k]));
      check("rr_in",    32'(cnt_in), 32'd1);
      wait_done(c);
      check("rr_len",  32'(c), 32'd3);
      check("rr_done", 32'(rq_if.done), 32'(rr_exp[k]));
    end
    rq_if.req = '0;
    step();

    // Up count on requester 2 from FD; later value/dir changes must be ignored
    rq_if.req_val[16 +: 8] = 8'hFD;
    rq_if.req_dir[2]       = 1'b0;
    rq_if.req              = 4'b0100;
    step();
    check("u_grant", 32'(rq_if.grant), 32'h4);
    check("u_in",    32'(cnt_in), 32'hFD);
    check("u_d",     32'(cnt_d), 32'd0);
    rq_if.req_val[16 +: 8] = 8'h10;
    rq_if.req_dir[2]       = 1'b1;
    step();
    check("u_q0", 32'(cnt_q), 32'hFD);
    check("u_e0", 32'(cnt_e), 32'd1);
    check("u_dl", 32'(cnt_d), 32'd0);
    step();
    check("u_q1", 32'(cnt_q), 32'hFE);
    check("u_e1", 32'(cnt_e), 32'd1);
    step();
    check("u_q2", 32'(cnt_q), 32'hFF);
    check("u_e2", 32'(cnt_e), 32'd0);
    step();
    check("u_done", 32'(rq_if.done), 32'h4);
    rq_if.req = '0;
    step();

    // Terminal start: requester 3, value 0 counting down
    rq_if.req_val[24 +: 8] = 8'd0;
    rq_if.req_dir[3]       = 1'b1;
    rq_if.req              = 4'b1000;
    step();
    check("t_grant", 32'(rq_if.grant), 32'h8);
    check("t_load",  32'(cnt_load), 32'd1);
    step();
    check("t_run_e",  32'(cnt_e), 32'd0);
    check("t_run_nd", 32'(rq_if.done), 32'd0);
    step();
    check("t_done", 32'(rq_if.done), 32'h8);
    check("t_e",    32'(cnt_e), 32'd0);
    rq_if.req = '0;
    step();

    // Abort: requester 2 drops with CntQ=5, requester 1 waiting is served next
    rq_if.req_val[16 +: 8] = 8'd8;
    rq_if.req_dir[2]       = 1'b1;
    rq_if.req_val[8 +: 8]  = 8'd9;
    rq_if.req_dir[1]       = 1'b1;
    rq_if.req              = 4'b0100;
    step();
    check("a_grant", 32'(rq_if.grant), 32'h4);
    rq_if.req = 4'b0110;
    for (int i = 0; i < 4; i++) step();
    check("a_q5", 32'(cnt_q), 32'd5);
    rq_if.req = 4'b0010;
    #1;
    check("a_e",  32'(cnt_e), 32'd0);
    check("a_nd", 32'(rq_if.done), 32'd0);
    step();
    check("a_gclr", 32'(rq_if.grant), 32'd0);
    check("a_busy", 32'(busy), 32'd0);
    check("a_nd2",  32'(rq_if.done), 32'd0);
    step();
    check("a_next", 32'(rq_if.grant), 32'h2);
    check("a_in",   32'(cnt_in), 32'd9);

    // Reset mid-RUN at CntQ=7, then pointer must be back at 0
    for (int i = 0; i < 3; i++) step();
    check("r_q7", 32'(cnt_q), 32'd7);
    rst_n = 1'b0;
    #1;
    check("r_grant", 32'(rq_if.grant), 32'd0);
    check("r_e",     32'(cnt_e), 32'd0);
    check("r_busy",  32'(busy), 32'd0);
    check("r_done",  32'(rq_if.done), 32'd0);
    rq_if.req = 4'b1001;
    step();
    rst_n = 1'b1;
    step();
    check("r_ptr0", 32'(rq_if.grant), 32'h1);
    rq_if.req = '0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
